// File: rtl/ugemm_rate_pkg.sv
// Shared types and sizing helpers for the rate-coded unary MAC stages.
package ugemm_rate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_LOGLEN = 8;

    // A stream of 2^loglen bits can hold up to 2^loglen ones, hence one extra bit.
    function automatic int cnt_width(input int loglen);
        return loglen + 1;
    endfunction

endpackage

// File: rtl/ubsg_cmp.sv
// Unary bitstream generator: emits 1 while the latched operand exceeds the Sobol sample.
module ubsg_cmp #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] sample,
    output logic             stream_bit
);

    assign stream_bit = (operand > sample);

endmodule

// File: rtl/umul_rate_acc16.sv
// Unipolar stochastic multiply-accumulate: ANDs two Sobol-driven bitstreams and counts ones.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for an operand pair, in_ready=1
// ST_RUN  | L cycles of stream generation, sobol_en=1
// ST_DONE | result held on out_cnt until out_ready
module umul_rate_acc16
    import ugemm_rate_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOGLEN = DEF_LOGLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [WIDTH-1:0]  sobol_a,
    input  logic [WIDTH-1:0]  sobol_b,
    output logic              sobol_en,
    output logic              bit_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOGLEN:0]   out_cnt
);

    localparam int CW = cnt_width(LOGLEN);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [LOGLEN-1:0]  cyc;
    logic [CW-1:0]      acc;
    logic               bit_a;
    logic               bit_b;
    logic               prod;
    logic               accept;
    logic               last_cyc;

    ubsg_cmp #(.WIDTH(WIDTH)) u_cmp_a (
        .operand    (a_reg),
        .sample     (sobol_a),
        .stream_bit (bit_a)
    );

    ubsg_cmp #(.WIDTH(WIDTH)) u_cmp_b (
        .operand    (b_reg),
        .sample     (sobol_b),
        .stream_bit (bit_b)
    );

    assign prod = bit_a & bit_b;

    // in_ready is combinational on out_ready while in ST_DONE (zero-bubble restart).
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign sobol_en  = (state == ST_RUN);
    assign accept    = in_valid && in_ready;
    assign last_cyc  = &cyc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            cyc     <= '0;
            acc     <= '0;
            out_cnt <= '0;
            bit_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        cyc   <= '0;
                        acc   <= '0;
                        state <= ST_RUN;
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc     <= acc + CW'(prod);
                    bit_out <= prod;
                    cyc     <= cyc + LOGLEN'(1);
                    if (last_cyc) begin
                        out_cnt <= acc + CW'(prod);
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umul_rate_acc16.sv
// Bench for umul_rate_acc16: ramp / bit-reversed Sobol stand-ins, vector table plus corner sequences.
module tb_umul_rate_acc16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] sobol_a;
    logic [15:0] sobol_b;
    logic        sobol_en;
    logic        bit_out;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_cnt;

    logic [7:0]  idx;
    logic        src_clear = 1'b1;
    logic        src_mode  = 1'b0;

    int checks = 0;
    int errors = 0;
    int sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        mode;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    umul_rate_acc16 #(.WIDTH(16), .LOGLEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .sobol_a   (sobol_a),
        .sobol_b   (sobol_b),
        .sobol_en  (sobol_en),
        .bit_out   (bit_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Sobol stand-in: advances only on edges where the DUT asserted sobol_en.
    always @(posedge clk) begin
        if (src_clear)     idx <= 8'd0;
        else if (sobol_en) idx <= idx + 8'd1;
    end

    assign sobol_a = {idx, 8'h00};
    assign sobol_b = src_mode ? {rev8(idx), 8'h00} : {idx, 8'h00};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_job(input logic [15:0] a, input logic [15:0] b,
                             input int exp, input bit push);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1; src_clear = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", int'(in_ready), 1);
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0; src_clear = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom);
    endtask

    // Called just after the accept edge; lat counts edges from the accept edge to out_valid.
    task automatic wait_done(input int glitch_at, output int lat, output int en, output int ones);
        int k;
        lat = 1; en = 0; ones = 0; k = 0;
        while (lat < 2000) begin
            @(negedge clk);
            k++;
            if (k > 1 && bit_out) ones++;
            if (out_valid) break;
            if (sobol_en) en++;
            if (k == glitch_at) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        chk("out_valid_done", int'(out_valid), 1);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got result %0d expected none", out_cnt);
        end else begin
            chk("out_cnt", int'(out_cnt), sb.pop_front());
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("done_to_idle_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        int lat, en, ones;
        vecs[0] = '{16'h8000, 16'hFFFF, 1'b0, 128};
        vecs[1] = '{16'h0000, 16'hFFFF, 1'b0, 0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 256};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 64};
        vecs[4] = '{16'h4000, 16'hFFFF, 1'b0, 64};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sobol_en", int'(sobol_en), 0);
        chk("rst_bit_out", int'(bit_out), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        rst_n = 1'b1;

        // Vector table; vector 0 also carries a between-edges rst_n glitch mid-RUN.
        for (int i = 0; i < 5; i++) begin
            src_mode = vecs[i].mode;
            start_job(vecs[i].a, vecs[i].b, vecs[i].exp_cnt, 1'b1);
            wait_done((i == 0) ? 50 : -1, lat, en, ones);
            chk($sformatf("v%0d_latency", i), lat, 257);
            chk($sformatf("v%0d_sobol_en_cycles", i), en, 256);
            chk($sformatf("v%0d_bit_out_ones", i), ones, vecs[i].exp_cnt);
            consume();
        end

        // Backpressure in DONE, then zero-bubble restart.
        src_mode = 1'b0;
        start_job(16'h8000, 16'hFFFF, 128, 1'b1);
        wait_done(-1, lat, en, ones);
        chk("bp_latency", lat, 257);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_cnt", int'(out_cnt), 128);
            chk("bp_sobol_en", int'(sobol_en), 0);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b1; in_a = 16'h4000; in_b = 16'hFFFF;
        out_ready = 1'b1; src_clear = 1'b1;
        #1;
        chk("b2b_in_ready", int'(in_ready), 1);
        chk("b2b_prev_cnt", int'(out_cnt), (sb.size() > 0) ? sb.pop_front() : -1);
        sb.push_back(64);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; src_clear = 1'b0;
        wait_done(-1, lat, en, ones);
        chk("b2b_latency", lat, 257);
        chk("b2b_sobol_en_cycles", en, 256);
        consume();

        // Reset mid-RUN abandons the job; the next job starts clean.
        start_job(16'h8000, 16'hFFFF, 0, 1'b0);
        repeat (100) @(negedge clk);
        chk("mid_run_sobol_en", int'(sobol_en), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_sobol_en", int'(sobol_en), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_bit_out", int'(bit_out), 0);
        chk("abort_out_cnt", int'(out_cnt), 0);
        start_job(16'h8000, 16'hFFFF, 128, 1'b1);
        wait_done(-1, lat, en, ones);
        chk("post_rst_latency", lat, 257);
        chk("post_rst_ones", ones, 128);
        consume();

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/umul_rate_acc16.md
Name: umul_rate_acc16

Overview:
- Rate-coded unary multiply-accumulate stage that sits directly downstream of two 16-bit Sobol sequence generators (dimensions A and B).
- Per job, it latches two unsigned operands and drives the generators' enable for exactly 2^LOGLEN cycles.
- Each cycle it compares each operand against its Sobol value to form two bitstreams, ANDs them (unipolar uMUL) and counts the ones.
- The count, approximately a*b*L/2^(2*WIDTH), is returned over a valid/ready handshake.

Parameters:
- WIDTH, 16, operand and Sobol sample width.
- LOGLEN, 8, log2 of bitstream length L; legal range 1..WIDTH.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  unsigned operand A.
- in_b  input  WIDTH  unsigned operand B.
- sobol_a  input  WIDTH  current Sobol sample, dimension A (from generator sobolSeq).
- sobol_b  input  WIDTH  current Sobol sample, dimension B.
- sobol_en  output  1  advance enable; drives the enable of both Sobol generators.
- bit_out  output  1  registered product bitstream (debug / downstream tap).
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_cnt  output  LOGLEN+1  ones count of the product stream, range 0..L.

Behaviour:
- Clocking and reset
  - One clock, clk. Reset is synchronous and active-low on rst_n and takes effect only at a clk edge.
  - Reset values: state=IDLE; a_reg, b_reg, cyc, acc, out_cnt = 0; in_ready=1 (follows from IDLE); sobol_en=0; bit_out=0; out_valid=0.
  - Reset mid-RUN abandons the job with no output. The Sobol generators are not cleared by this block.
- State machine, states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid: latch in_a/in_b, set cyc=0, acc=0, go to RUN.
  - RUN: sobol_en=1 combinationally for every RUN cycle and 0 otherwise. in_ready=0.
    - Each cycle: bit_a = (a_reg > sobol_a), bit_b = (b_reg > sobol_b), p = bit_a & bit_b.
    - Updates: acc <= acc + p; bit_out <= p; cyc <= cyc + 1.
    - The sample present in a cycle is consumed in that same cycle; the generator advances on that edge because of sobol_en.
    - RUN lasts exactly L cycles. On the cycle where cyc == L-1: out_cnt <= acc + p, go to DONE.
  - DONE: out_valid=1 and out_cnt is held stable until out_ready.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: in_ready=1 in this cycle. Latch the new operands, clear cyc/acc, go directly to RUN. This gives zero bubble between jobs.
    - out_ready=0: in_ready=0 and the state holds indefinitely.
- Job latency: L+1 cycles from the in_valid&in_ready edge to out_valid=1 (one cycle to enter RUN, L cycles in RUN).
- Throughput: one job per L+1 cycles under continuous handshakes.
- Arithmetic and width:
  - Compares are strict unsigned greater-than. Operand 0 yields an all-zero stream.
  - acc is LOGLEN+1 bits; the maximum count is L, so no overflow or saturation is needed.
  - cyc is LOGLEN bits and wraps to 0 as RUN exits.
- Outputs: in_ready, out_valid and sobol_en are functions of state (and out_ready in DONE) only. in_ready therefore depends combinationally on out_ready in DONE, and must be documented as such for integrators.
- Changes to in_a/in_b while not handshaking are ignored.

Decomposition:
- Shared package ugemm_rate_pkg:
  - state typedef enum {IDLE, RUN, DONE} (2-bit);
  - default WIDTH and LOGLEN constants;
  - function for count width (LOGLEN+1).
- Sub-module ubsg_cmp: unary bitstream generator, a WIDTH-bit strict greater-than comparator of a latched operand against a Sobol sample. Instantiated twice (A and B).
- FSM, counters and accumulator stay in the top module.

Test Plan:
- Ramp source: bench drives sobol_a = sobol_b = (index<<8) for index 0..255, advancing only when sobol_en=1; LOGLEN=8; a=0x8000, b=0xFFFF -> out_cnt=128, sobol_en high for exactly 256 cycles, out_valid rises 257 cycles after accept.
- Zero and full operands with the same source: a=0x0000, b=0xFFFF -> out_cnt=0 and bit_out never 1. a=b=0xFFFF -> out_cnt=256 (max value, no overflow).
- Independent sources: sobol_a ramp as above, sobol_b = bit-reversed 8-bit index <<8; a=b=0x8000 -> out_cnt=64.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 20 cycles in DONE -> out_valid/out_cnt stable, sobol_en=0, in_ready=0.
  - Then assert out_ready with in_valid=1 (a=0x4000, b=0xFFFF, ramp) -> accepted in the same cycle, RUN restarts with no IDLE cycle, next out_cnt=64.
- Reset: assert rst_n=0 for one edge at RUN cycle 100 -> next cycle state IDLE, sobol_en=0, out_valid=0, acc=0. The following job with a=0x8000, b=0xFFFF on a fresh ramp -> out_cnt=128.
- Synchronous reset check: pulse rst_n low between clock edges only -> no state change.
